// File: rtl/sdram_pro_read_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pro_read_pkg
// Shared SDRAM command encodings used by both the read and the write paths.
// Commands are {CS_n, RAS_n, CAS_n, WE_n}.
// The package also holds the idle address/bank values driven with NOP, and
// helpers that split the 23-bit linear address into bank, row and column.
// -----------------------------------------------------------------------------
package sdram_pro_read_pkg;

   localparam logic [3:0] NO_OPERATION    = 4'b0111;
   localparam logic [3:0] ACTIVE          = 4'b0011;
   localparam logic [3:0] READ            = 4'b0101;
   localparam logic [3:0] BURST_TERMINATE = 4'b0110;
   localparam logic [3:0] PRECHARGE       = 4'b0010;

   localparam logic [11:0] ADDR_IDLE = 12'hfff;
   localparam logic [1:0]  BANK_IDLE = 2'b11;

   // Linear address layout: bank[22:21], row[20:9], column[8:0]
   function automatic logic [1:0] bank_of(input logic [22:0] addr);
      return addr[22:21];
   endfunction

   function automatic logic [11:0] row_of(input logic [22:0] addr);
      return addr[20:9];
   endfunction

   function automatic logic [11:0] col_of(input logic [22:0] addr);
      return {3'b000, addr[8:0]};
   endfunction

endpackage

// File: rtl/sdram_pro_read.sv
// -----------------------------------------------------------------------------
// sdram_pro_read
// SDRAM read-burst controller. When the arbiter requests a read after
// initialization, it issues ACTIVE, then READ. It ends the burst with
// BURST_TERMINATE after N words, then issues PRECHARGE, and finally pulses
// rd_end. Every SDRAM-side output is registered from the current state, so the
// bus lags the FSM by one cycle.
//
// Ports
//   sys_clk, sys_rst_n      clock (rising edge), async active-low reset
//   init_end                SDRAM initialization complete
//   rd_en                   read request from arbiter
//   rd_addr[22:0]           bank[22:21], row[20:9], column[8:0]
//   rd_burst_len[7:0]       words to read (0 is treated as 1)
//   rd_sdram_data[15:0]     SDRAM DQ input
//   rd_sdram_cmd[3:0]       registered command
//   rd_sdram_addr[11:0]     registered address
//   rd_sdram_bank[1:0]      registered bank
//   rd_data[15:0]           registered DQ word, to FIFO
//   rd_ack                  rd_data valid / FIFO write enable
//   rd_end                  one-cycle read-complete pulse
// -----------------------------------------------------------------------------
module sdram_pro_read
   import sdram_pro_read_pkg::*;
#(
   parameter int CNT_TRCD = 2,
   parameter int CNT_TRP  = 2,
   parameter int CAS_LAT  = 3
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        init_end,
   input  logic        rd_en,
   input  logic [22:0] rd_addr,
   input  logic [7:0]  rd_burst_len,
   input  logic [15:0] rd_sdram_data,
   output logic [3:0]  rd_sdram_cmd,
   output logic [11:0] rd_sdram_addr,
   output logic [1:0]  rd_sdram_bank,
   output logic [15:0] rd_data,
   output logic        rd_ack,
   output logic        rd_end
);

   typedef enum logic [3:0] {
      RD_IDLE, RD_ACTIVE, RD_TRCD, RD_READ, RD_DATA,
      RD_CL_WAIT, RD_PRECHARGE, RD_TRP, RD_END
   } rd_state_t;

   localparam logic [7:0] TRCD_LAST = 8'(CNT_TRCD - 1);
   localparam logic [7:0] TRP_LAST  = 8'(CNT_TRP - 1);
   localparam logic [7:0] CL_LAST   = 8'(CAS_LAT - 1);

   rd_state_t        state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       len_q, len_d;
   logic [22:0]      addr_q, addr_d;
   logic [CAS_LAT:0] ack_pipe_q, ack_pipe_d;
   logic [3:0]       cmd_q, cmd_d;
   logic [11:0]      sd_addr_q, sd_addr_d;
   logic [1:0]       bank_q, bank_d;
   logic [15:0]      data_q, data_d;
   logic             end_q, end_d;
   logic             last_word;

   assign last_word = (cnt_q == len_q - 8'd1);

   // Next-state logic: one shared counter times every wait and the burst
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      addr_d  = addr_q;
      case (state_q)
         RD_IDLE: begin
            if (init_end && rd_en) begin
               state_d = RD_ACTIVE;
               addr_d  = rd_addr;
               len_d   = (rd_burst_len == 8'd0) ? 8'd1 : rd_burst_len;
               cnt_d   = 8'd0;
            end
         end
         RD_ACTIVE: begin
            state_d = RD_TRCD;
            cnt_d   = 8'd0;
         end
         RD_TRCD: begin
            if (cnt_q == TRCD_LAST) begin
               state_d = RD_READ;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RD_READ: begin
            state_d = RD_DATA;
            cnt_d   = 8'd0;
         end
         RD_DATA: begin
            if (last_word) begin
               state_d = RD_CL_WAIT;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RD_CL_WAIT: begin
            if (cnt_q == CL_LAST) begin
               state_d = RD_PRECHARGE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RD_PRECHARGE: begin
            state_d = RD_TRP;
            cnt_d   = 8'd0;
         end
         RD_TRP: begin
            if (cnt_q == TRP_LAST) begin
               state_d = RD_END;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RD_END: begin
            state_d = RD_IDLE;
         end
         default: begin
            state_d = RD_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Command/output decode from the current state; registered below
   always_comb begin
      cmd_d     = NO_OPERATION;
      sd_addr_d = ADDR_IDLE;
      bank_d    = BANK_IDLE;
      case (state_q)
         RD_ACTIVE: begin
            cmd_d     = ACTIVE;
            sd_addr_d = row_of(addr_q);
            bank_d    = bank_of(addr_q);
         end
         RD_READ: begin
            cmd_d     = READ;
            sd_addr_d = col_of(addr_q);
            bank_d    = bank_of(addr_q);
         end
         RD_DATA: begin
            if (last_word) cmd_d = BURST_TERMINATE;
         end
         RD_PRECHARGE: begin
            cmd_d  = PRECHARGE;
            bank_d = bank_of(addr_q);
         end
         default: ;
      endcase
      // The RD_DATA window, delayed by CAS_LAT+1, marks the cycles in which
      // the registered DQ word holds burst data.
      ack_pipe_d = {ack_pipe_q[CAS_LAT-1:0], state_q == RD_DATA};
      data_d     = rd_sdram_data;
      end_d      = (state_q == RD_END);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= RD_IDLE;
         cnt_q      <= 8'd0;
         len_q      <= 8'd1;
         addr_q     <= 23'd0;
         ack_pipe_q <= '0;
         cmd_q      <= NO_OPERATION;
         sd_addr_q  <= ADDR_IDLE;
         bank_q     <= BANK_IDLE;
         data_q     <= 16'd0;
         end_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         ack_pipe_q <= ack_pipe_d;
         cmd_q      <= cmd_d;
         sd_addr_q  <= sd_addr_d;
         bank_q     <= bank_d;
         data_q     <= data_d;
         end_q      <= end_d;
      end
   end

   assign rd_sdram_cmd  = cmd_q;
   assign rd_sdram_addr = sd_addr_q;
   assign rd_sdram_bank = bank_q;
   assign rd_data       = data_q;
   assign rd_ack        = ack_pipe_q[CAS_LAT];
   assign rd_end        = end_q;

endmodule

// File: tb/tb_sdram_pro_read.sv
// -----------------------------------------------------------------------------
// tb_sdram_pro_read
// Directed and randomized read bursts against sdram_pro_read. Expected bus
// activity for each request is derived from the request cycle with plain
// timing arithmetic, and a DQ source supplies base+i for word i.
// -----------------------------------------------------------------------------
module tb_sdram_pro_read;

   localparam int TRCD = 2;
   localparam int TRP  = 2;
   localparam int CL   = 3;

   // {CS_n, RAS_n, CAS_n, WE_n}
   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_BST = 4'b0110;
   localparam logic [3:0] C_PRE = 4'b0010;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        init_end;
   logic        rd_en;
   logic [22:0] rd_addr;
   logic [7:0]  rd_burst_len;
   logic [15:0] rd_sdram_data;
   logic [3:0]  rd_sdram_cmd;
   logic [11:0] rd_sdram_addr;
   logic [1:0]  rd_sdram_bank;
   logic [15:0] rd_data;
   logic        rd_ack;
   logic        rd_end;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [15:0] exp_rd_data;

   sdram_pro_read #(
      .CNT_TRCD (TRCD),
      .CNT_TRP  (TRP),
      .CAS_LAT  (CL)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .init_end      (init_end),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_burst_len  (rd_burst_len),
      .rd_sdram_data (rd_sdram_data),
      .rd_sdram_cmd  (rd_sdram_cmd),
      .rd_sdram_addr (rd_sdram_addr),
      .rd_sdram_bank (rd_sdram_bank),
      .rd_data       (rd_data),
      .rd_ack        (rd_ack),
      .rd_end        (rd_end)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL timeout cycle %0d", cyc);
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // Advance one clock; sample #1 after the edge. rd_data must hold whatever
   // DQ carried at the edge unless reset was low.
   task automatic step();
      @(posedge sys_clk);
      #1;
      cyc++;
      exp_rd_data = sys_rst_n ? rd_sdram_data : 16'h0000;
   endtask

   task automatic chk_cycle(input string w, input logic [3:0] c, input logic [11:0] a,
                            input logic [1:0] b, input logic ack, input logic e);
      chk({w, ":cmd"},  32'(rd_sdram_cmd),  32'(c));
      chk({w, ":addr"}, 32'(rd_sdram_addr), 32'(a));
      chk({w, ":bank"}, 32'(rd_sdram_bank), 32'(b));
      chk({w, ":ack"},  32'(rd_ack),        32'(ack));
      chk({w, ":end"},  32'(rd_end),        32'(e));
      chk({w, ":data"}, 32'(rd_data),       32'(exp_rd_data));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         chk_cycle("idle", C_NOP, 12'hfff, 2'b11, 1'b0, 1'b0);
         rd_sdram_data = 16'($urandom);
      end
   endtask

   // Issue one request in the current cycle and check every cycle up to and
   // including the rd_end pulse. abort_ack>0 asserts reset right after the
   // abort_ack-th rd_ack cycle has been checked.
   task automatic run_txn(input logic [22:0] a, input logic [7:0] len,
                          input logic [15:0] base, input int abort_ack);
      int n, c0, ta, tr, tp, te;
      n  = (len == 8'd0) ? 1 : int'(len);
      init_end      = 1'b1;
      rd_en         = 1'b1;
      rd_addr       = a;
      rd_burst_len  = len;
      rd_sdram_data = 16'($urandom);
      c0 = cyc;
      ta = c0 + 2;               // ACTIVE on bus
      tr = ta + 1 + TRCD;        // READ on bus
      tp = tr + n + CL + 1;      // PRECHARGE on bus
      te = tp + TRP + 1;         // rd_end pulse
      for (int t = c0 + 1; t <= te; t++) begin
         logic [3:0]  ec;
         logic [11:0] ea;
         logic [1:0]  eb;
         logic        eack;
         step();
         ec = C_NOP;
         ea = 12'hfff;
         eb = 2'b11;
         if (t == ta) begin
            ec = C_ACT; ea = a[20:9]; eb = a[22:21];
         end else if (t == tr) begin
            ec = C_RD; ea = {3'b000, a[8:0]}; eb = a[22:21];
         end else if (t == tr + n) begin
            ec = C_BST;
         end else if (t == tp) begin
            ec = C_PRE; eb = a[22:21];
         end
         eack = (t >= tr + CL + 1) && (t <= tr + CL + n);
         chk_cycle("txn", ec, ea, eb, eack, t == te);
         if (eack) chk("txn:word", 32'(rd_data), 32'(16'(base + 16'(t - tr - CL - 1))));
         if (abort_ack != 0 && t == tr + CL + abort_ack) begin
            sys_rst_n = 1'b0;
            rd_en     = 1'b0;
            #1;
            exp_rd_data = 16'h0000;
            chk_cycle("rst_async", C_NOP, 12'hfff, 2'b11, 1'b0, 1'b0);
            return;
         end
         // request inputs toggle freely once captured
         rd_en        = 1'($urandom);
         rd_addr      = 23'($urandom);
         rd_burst_len = 8'($urandom);
         rd_sdram_data = (t >= tr + CL && t < tr + CL + n) ? 16'(base + 16'(t - tr - CL))
                                                           : 16'($urandom);
      end
      rd_en = 1'b0;
   endtask

   initial begin
      sys_rst_n     = 1'b0;
      init_end      = 1'b0;
      rd_en         = 1'b0;
      rd_addr       = 23'd0;
      rd_burst_len  = 8'd0;
      rd_sdram_data = 16'hbeef;

      // Reset values
      repeat (2) step();
      chk_cycle("reset", C_NOP, 12'hfff, 2'b11, 1'b0, 1'b0);
      sys_rst_n = 1'b1;
      init_end  = 1'b1;
      idle(3);

      // Basic burst: bank 1, row 12'h500, column 5, eight words
      run_txn(23'h2A_0005, 8'd8, 16'h0100, 0);
      idle(2);

      // Length boundaries
      run_txn(23'($urandom), 8'd1, 16'($urandom), 0);
      idle(1);
      run_txn(23'($urandom), 8'd0, 16'($urandom), 0);
      idle(1);
      run_txn(23'($urandom), 8'd255, 16'($urandom), 0);
      idle(2);

      // Gating: request held while init_end low
      init_end = 1'b0;
      rd_en    = 1'b1;
      rd_addr  = 23'h7F_FFFF;
      idle(20);
      run_txn(23'h15_A3C1, 8'd3, 16'h4000, 0);
      idle(2);

      // Reset at the 4th rd_ack, then a normal request
      run_txn(23'($urandom), 8'd10, 16'h2000, 4);
      repeat (2) begin
         step();
         chk_cycle("in_reset", C_NOP, 12'hfff, 2'b11, 1'b0, 1'b0);
      end
      sys_rst_n = 1'b1;
      idle(12);
      run_txn(23'($urandom), 8'd6, 16'h3000, 0);

      // Back-to-back requests with rd_en held
      run_txn(23'h00_0001, 8'd4, 16'h5000, 0);
      run_txn(23'h7F_FE00, 8'd2, 16'h6000, 0);
      run_txn(23'($urandom), 8'($urandom_range(1, 12)), 16'($urandom), 0);
      idle(2);

      // Randomized requests
      for (int i = 0; i < 8; i++) begin
         run_txn(23'($urandom), 8'($urandom_range(0, 24)), 16'($urandom), 0);
         idle($urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
